// File: rtl/hazard_scoreboard.sv
// Decode-stage issue control: tracks pending int/vector register writes, blocks RAW/WAW
// hazards, sequences end-of-program drain to halt, and flags long stalls.
module hazard_scoreboard #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter bit BYPASS_WB = 1'b1,
  parameter int TIMEOUT   = 64,
  parameter int CNT_BITS  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_i,
  input  logic                      src1_int_i,
  input  logic                      src2_int_i,
  input  logic [REGI_BITS-1:0]      int_src1_i,
  input  logic [REGI_BITS-1:0]      int_src2_i,
  input  logic                      src1_vec_i,
  input  logic                      src2_vec_i,
  input  logic [VECT_BITS-1:0]      vec_src1_i,
  input  logic [VECT_BITS-1:0]      vec_src2_i,
  input  logic                      wr_int_i,
  input  logic [REGI_BITS-1:0]      int_dest_i,
  input  logic                      wr_vec_i,
  input  logic [VECT_BITS-1:0]      vec_dest_i,
  input  logic                      is_end_i,
  input  logic                      flush_i,
  input  logic                      int_we_i,
  input  logic [REGI_BITS-1:0]      int_wb_dest_i,
  input  logic                      vec_we_i,
  input  logic [VECT_BITS-1:0]      vec_wb_dest_i,
  output logic                      issue_o,
  output logic                      stall_o,
  output logic [(1<<REGI_BITS)-1:0] int_busy_o,
  output logic [(1<<VECT_BITS)-1:0] vec_busy_o,
  output logic [CNT_BITS-1:0]       outstanding_o,
  output logic                      halted_o,
  output logic                      error_o
);

  localparam int NI      = 1 << REGI_BITS;
  localparam int NV      = 1 << VECT_BITS;
  localparam int WD_BITS = $clog2(TIMEOUT + 1);
  localparam logic [WD_BITS-1:0]  WD_MAX  = WD_BITS'(TIMEOUT);
  localparam logic [CNT_BITS+1:0] CNT_MAX = {2'b00, {CNT_BITS{1'b1}}};

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  state_t               state;
  logic [WD_BITS-1:0]   wd_cnt;
  logic [WD_BITS-1:0]   wd_nxt;
  logic [NI-1:0]        int_clr, int_eff, int_set, int_nxt;
  logic [NV-1:0]        vec_clr, vec_eff, vec_set, vec_nxt;
  logic                 raw, waw, hazard;
  logic [1:0]           inc, dec;
  logic [CNT_BITS+1:0]  cnt_up, cnt_dec, cnt_diff;
  logic [CNT_BITS-1:0]  cnt_nxt;

  // Only a writeback that hits a pending bit counts as a clear; others are ignored.
  always_comb begin
    int_clr = (int_we_i ? (NI'(1) << int_wb_dest_i) : '0) & int_busy_o;
    vec_clr = (vec_we_i ? (NV'(1) << vec_wb_dest_i) : '0) & vec_busy_o;
    int_eff = BYPASS_WB ? (int_busy_o & ~int_clr) : int_busy_o;
    vec_eff = BYPASS_WB ? (vec_busy_o & ~vec_clr) : vec_busy_o;
  end

  assign raw = (src1_int_i & int_eff[int_src1_i]) | (src2_int_i & int_eff[int_src2_i]) |
               (src1_vec_i & vec_eff[vec_src1_i]) | (src2_vec_i & vec_eff[vec_src2_i]);
  assign waw    = (wr_int_i & int_eff[int_dest_i]) | (wr_vec_i & vec_eff[vec_dest_i]);
  assign hazard = raw | waw;

  assign issue_o = issue_valid_i & ~hazard & ~flush_i & (state == RUN);
  assign stall_o = issue_valid_i & ~flush_i & ~issue_o;

  // Set is applied after clear so a same-cycle set on the same register wins.
  always_comb begin
    int_set = (issue_o & wr_int_i) ? (NI'(1) << int_dest_i) : '0;
    vec_set = (issue_o & wr_vec_i) ? (NV'(1) << vec_dest_i) : '0;
    int_nxt = (int_busy_o & ~int_clr) | int_set;
    vec_nxt = (vec_busy_o & ~vec_clr) | vec_set;
  end

  always_comb begin
    inc      = {1'b0, |int_set} + {1'b0, |vec_set};
    dec      = {1'b0, |int_clr} + {1'b0, |vec_clr};
    cnt_up   = {2'b00, outstanding_o} + {CNT_BITS'(0), inc};
    cnt_dec  = {CNT_BITS'(0), dec};
    cnt_diff = cnt_up - cnt_dec;
    if (cnt_up < cnt_dec)
      cnt_nxt = '0;
    else if (cnt_diff > CNT_MAX)
      cnt_nxt = '1;
    else
      cnt_nxt = cnt_diff[CNT_BITS-1:0];
  end

  always_comb begin
    wd_nxt = '0;
    if ((state == RUN) && stall_o)
      wd_nxt = (wd_cnt == WD_MAX) ? WD_MAX : wd_cnt + WD_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      int_busy_o    <= '0;
      vec_busy_o    <= '0;
      outstanding_o <= '0;
      wd_cnt        <= '0;
      halted_o      <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      int_busy_o    <= int_nxt;
      vec_busy_o    <= vec_nxt;
      outstanding_o <= cnt_nxt;
      wd_cnt        <= wd_nxt;
      if (wd_nxt == WD_MAX)
        error_o <= 1'b1;
      case (state)
        RUN: if (issue_o && is_end_i) state <= DRAIN;
        DRAIN: begin
          if ((int_nxt == '0) && (vec_nxt == '0)) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two DUTs (writeback bypass on/off) share stimulus and are
// compared every cycle against a per-register behavioural model, plus directed literal checks.
module tb_hazard_scoreboard;

  localparam int NI = 16;
  localparam int NV = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  logic valid, s1i, s2i, s1v, s2v, wr_int, wr_vec, is_end, flush, int_we, vec_we;
  logic [3:0] int_src1, int_src2, int_dest, int_wb_dest;
  logic [1:0] vec_src1, vec_src2, vec_dest, vec_wb_dest;

  logic issue_b, stall_b, halted_b, error_b, issue_n, stall_n, halted_n, error_n;
  logic [15:0] ibusy_b, ibusy_n;
  logic [3:0]  vbusy_b, vbusy_n;
  logic [4:0]  cnt_b, cnt_n;

  int tests = 0;
  int fails = 0;

  // Model: index 0 mirrors the bypass DUT, index 1 the non-bypass DUT.
  bit byp [2] = '{1'b1, 1'b0};
  bit m_ip [2][NI];
  bit m_vp [2][NV];
  int m_cnt [2];
  int m_wd [2];
  bit m_drain [2];
  bit m_halt [2];
  bit m_err [2];
  string nm [7] = '{"issue", "stall", "int_busy", "vec_busy", "outstanding", "halted", "error"};

  always #5 clk = ~clk;

  hazard_scoreboard #(.BYPASS_WB(1'b1)) dut_b (
    .clk(clk), .rst(rst), .issue_valid_i(valid),
    .src1_int_i(s1i), .src2_int_i(s2i), .int_src1_i(int_src1), .int_src2_i(int_src2),
    .src1_vec_i(s1v), .src2_vec_i(s2v), .vec_src1_i(vec_src1), .vec_src2_i(vec_src2),
    .wr_int_i(wr_int), .int_dest_i(int_dest), .wr_vec_i(wr_vec), .vec_dest_i(vec_dest),
    .is_end_i(is_end), .flush_i(flush), .int_we_i(int_we), .int_wb_dest_i(int_wb_dest),
    .vec_we_i(vec_we), .vec_wb_dest_i(vec_wb_dest), .issue_o(issue_b), .stall_o(stall_b),
    .int_busy_o(ibusy_b), .vec_busy_o(vbusy_b), .outstanding_o(cnt_b),
    .halted_o(halted_b), .error_o(error_b));

  hazard_scoreboard #(.BYPASS_WB(1'b0)) dut_n (
    .clk(clk), .rst(rst), .issue_valid_i(valid),
    .src1_int_i(s1i), .src2_int_i(s2i), .int_src1_i(int_src1), .int_src2_i(int_src2),
    .src1_vec_i(s1v), .src2_vec_i(s2v), .vec_src1_i(vec_src1), .vec_src2_i(vec_src2),
    .wr_int_i(wr_int), .int_dest_i(int_dest), .wr_vec_i(wr_vec), .vec_dest_i(vec_dest),
    .is_end_i(is_end), .flush_i(flush), .int_we_i(int_we), .int_wb_dest_i(int_wb_dest),
    .vec_we_i(vec_we), .vec_wb_dest_i(vec_wb_dest), .issue_o(issue_n), .stall_o(stall_n),
    .int_busy_o(ibusy_n), .vec_busy_o(vbusy_n), .outstanding_o(cnt_n),
    .halted_o(halted_n), .error_o(error_n));

  // ---------------- behavioural model ----------------
  function automatic bit ip_eff(int k, int r);
    return m_ip[k][r] && !(byp[k] && int_we && int'(int_wb_dest) == r);
  endfunction

  function automatic bit vp_eff(int k, int r);
    return m_vp[k][r] && !(byp[k] && vec_we && int'(vec_wb_dest) == r);
  endfunction

  function automatic bit exp_issue(int k);
    if (!valid || flush || m_drain[k] || m_halt[k]) return 1'b0;
    if (s1i && ip_eff(k, int_src1)) return 1'b0;
    if (s2i && ip_eff(k, int_src2)) return 1'b0;
    if (s1v && vp_eff(k, vec_src1)) return 1'b0;
    if (s2v && vp_eff(k, vec_src2)) return 1'b0;
    if (wr_int && ip_eff(k, int_dest)) return 1'b0;
    if (wr_vec && vp_eff(k, vec_dest)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall(int k);
    return valid && !flush && !exp_issue(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NI; r++) m_ip[k][r] = 1'b0;
      for (int r = 0; r < NV; r++) m_vp[k][r] = 1'b0;
      m_cnt[k] = 0; m_wd[k] = 0;
      m_drain[k] = 1'b0; m_halt[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    bit iss, stl, run, none;
    iss = exp_issue(k);
    stl = exp_stall(k);
    run = !m_drain[k] && !m_halt[k];
    if (int_we && m_ip[k][int_wb_dest]) begin m_ip[k][int_wb_dest] = 1'b0; m_cnt[k]--; end
    if (vec_we && m_vp[k][vec_wb_dest]) begin m_vp[k][vec_wb_dest] = 1'b0; m_cnt[k]--; end
    if (iss && wr_int) begin m_ip[k][int_dest] = 1'b1; m_cnt[k]++; end
    if (iss && wr_vec) begin m_vp[k][vec_dest] = 1'b1; m_cnt[k]++; end
    if (m_cnt[k] > 31) m_cnt[k] = 31;
    if (m_cnt[k] < 0) m_cnt[k] = 0;
    if (run && iss && is_end) m_drain[k] = 1'b1;
    else if (m_drain[k]) begin
      none = 1'b1;
      for (int r = 0; r < NI; r++) if (m_ip[k][r]) none = 1'b0;
      for (int r = 0; r < NV; r++) if (m_vp[k][r]) none = 1'b0;
      if (none) begin m_drain[k] = 1'b0; m_halt[k] = 1'b1; end
    end
    m_wd[k] = (run && stl) ? ((m_wd[k] < TO) ? m_wd[k] + 1 : TO) : 0;
    if (m_wd[k] >= TO) m_err[k] = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  function automatic logic [31:0] mdl_out(int k, int s);
    logic [31:0] v;
    v = '0;
    case (s)
      0: v[0] = exp_issue(k);
      1: v[0] = exp_stall(k);
      2: for (int r = 0; r < NI; r++) v[r] = m_ip[k][r];
      3: for (int r = 0; r < NV; r++) v[r] = m_vp[k][r];
      4: v = 32'(m_cnt[k]);
      5: v[0] = m_halt[k];
      default: v[0] = m_err[k];
    endcase
    return v;
  endfunction

  function automatic logic [31:0] dut_out(int k, int s);
    case (s)
      0: return 32'(k == 0 ? issue_b : issue_n);
      1: return 32'(k == 0 ? stall_b : stall_n);
      2: return 32'(k == 0 ? ibusy_b : ibusy_n);
      3: return 32'(k == 0 ? vbusy_b : vbusy_n);
      4: return 32'(k == 0 ? cnt_b : cnt_n);
      5: return 32'(k == 0 ? halted_b : halted_n);
      default: return 32'(k == 0 ? error_b : error_n);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic lit(int k, int s, logic [31:0] exp);
    chk({"lit_", nm[s]}, k, dut_out(k, s), exp);
  endtask

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 7; s++)
        chk(nm[s], k, dut_out(k, s), mdl_out(k, s));
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    {valid, s1i, s2i, s1v, s2v, wr_int, wr_vec, is_end, flush, int_we, vec_we} = '0;
    int_src1 = '0; int_src2 = '0; int_dest = '0; int_wb_dest = '0;
    vec_src1 = '0; vec_src2 = '0; vec_dest = '0; vec_wb_dest = '0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #3;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 7; s++) lit(k, s, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    valid  = ($urandom_range(0, 99) < 85);
    flush  = ($urandom_range(0, 99) < 8);
    s1i = $urandom_range(0, 1); s2i = $urandom_range(0, 1);
    s1v = $urandom_range(0, 1); s2v = $urandom_range(0, 1);
    int_src1 = 4'($urandom_range(0, 15)); int_src2 = 4'($urandom_range(0, 15));
    vec_src1 = 2'($urandom_range(0, 3));  vec_src2 = 2'($urandom_range(0, 3));
    wr_int = ($urandom_range(0, 99) < 60); int_dest = 4'($urandom_range(0, 15));
    wr_vec = ($urandom_range(0, 99) < 40); vec_dest = 2'($urandom_range(0, 3));
    is_end = ($urandom_range(0, 299) == 0);
    int_we = ($urandom_range(0, 99) < 55); int_wb_dest = 4'($urandom_range(0, 15));
    vec_we = ($urandom_range(0, 99) < 45); vec_wb_dest = 2'($urandom_range(0, 3));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    do_reset();

    // RAW on r3, released by a writeback (same cycle with bypass, next cycle without)
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 3; #3;
    lit(0, 0, 1); lit(1, 0, 1);
    begin_cycle(); valid = 1; s1i = 1; int_src1 = 3; #3;
    lit(0, 0, 0); lit(0, 1, 1); lit(1, 1, 1); lit(0, 2, 32'h8); lit(1, 2, 32'h8);
    begin_cycle(); valid = 1; s1i = 1; int_src1 = 3; int_we = 1; int_wb_dest = 3; #3;
    lit(0, 0, 1); lit(1, 0, 0);
    begin_cycle(); valid = 1; s1i = 1; int_src1 = 3; #3;
    lit(1, 0, 1); lit(0, 2, 0); lit(1, 2, 0); lit(1, 4, 0);
    do_reset();

    // WAW on v2; integer writeback to r2 does not release it
    begin_cycle(); valid = 1; wr_vec = 1; vec_dest = 2; #3;
    begin_cycle(); valid = 1; wr_vec = 1; vec_dest = 2; int_we = 1; int_wb_dest = 2; #3;
    lit(0, 0, 0); lit(1, 1, 1); lit(0, 3, 32'h4);
    begin_cycle(); valid = 1; wr_vec = 1; vec_dest = 2; vec_we = 1; vec_wb_dest = 2; #3;
    lit(0, 4, 1); lit(0, 0, 1); lit(1, 0, 0);
    begin_cycle(); #3;
    lit(0, 3, 32'h4); lit(0, 4, 1); lit(1, 3, 0); lit(1, 4, 0);
    do_reset();

    // Same-cycle set and clear on r5
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 5; #3;
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 5; int_we = 1; int_wb_dest = 5; #3;
    begin_cycle(); #3;
    lit(0, 2, 32'h20); lit(0, 4, 1); lit(1, 2, 0); lit(1, 4, 0);
    do_reset();

    // Flush, dual write, end instruction, drain, halt, reset
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 1; #3;
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 7; flush = 1; #3;
    lit(0, 0, 0); lit(0, 1, 0);
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 4; wr_vec = 1; vec_dest = 0; #3;
    lit(0, 2, 32'h2); lit(0, 4, 1); lit(0, 0, 1);
    begin_cycle(); valid = 1; is_end = 1; #3;
    lit(0, 4, 3); lit(0, 2, 32'h12); lit(0, 3, 32'h1); lit(0, 0, 1);
    begin_cycle(); valid = 1; #3;
    lit(0, 0, 0); lit(0, 1, 1); lit(0, 5, 0);
    begin_cycle(); int_we = 1; int_wb_dest = 1; vec_we = 1; vec_wb_dest = 0; #3;
    begin_cycle(); int_we = 1; int_wb_dest = 4; #3;
    lit(0, 4, 1); lit(0, 5, 0);
    begin_cycle(); valid = 1; #3;
    lit(0, 5, 1); lit(1, 5, 1); lit(0, 4, 0); lit(0, 0, 0); lit(0, 1, 1);
    do_reset();

    // Stall watchdog on r1 that never writes back
    begin_cycle(); valid = 1; wr_int = 1; int_dest = 1; #3;
    for (int i = 0; i < TO - 1; i++) begin
      begin_cycle(); valid = 1; s1i = 1; int_src1 = 1;
    end
    begin_cycle(); valid = 1; s1i = 1; int_src1 = 1; #3;
    lit(0, 6, 0); lit(1, 6, 0);
    begin_cycle(); int_we = 1; int_wb_dest = 1; #3;
    lit(0, 6, 1); lit(1, 6, 1);
    for (int i = 0; i < 5; i++) begin_cycle();
    #3;
    lit(0, 6, 1); lit(1, 6, 1);
    do_reset();

    // Randomized traffic, with occasional resets (some of them mid-drain)
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 249) == 0 || (m_halt[0] && m_halt[1] && $urandom_range(0, 9) == 0))
        do_reset();
      else begin
        begin_cycle();
        rand_inputs();
      end
    end

    begin_cycle();
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-control block for the decode stage. It sits between instruction decode and the ID/EX pipe register.
- Tracks pending writes to the integer and vector register files, and detects RAW and WAW hazards against the instruction in decode.
- Drives the stall/issue handshake and sequences end-of-program drain to halt.
- Flags a stuck pipeline with a stall watchdog.

Parameters:
REGI_BITS, 4, integer register address width (2**REGI_BITS registers)
VECT_BITS, 2, vector register address width (2**VECT_BITS registers)
BYPASS_WB, 1, 1 = a writeback in the same cycle clears the hazard for that cycle's check; 0 = hazard clears one cycle after writeback
TIMEOUT, 64, consecutive stall cycles before error_o is set
CNT_BITS, 5, width of the outstanding-write counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
issue_valid_i  in  1  decode holds a valid instruction
src1_int_i, src2_int_i  in  1  operand 1/2 reads an integer register
int_src1_i, int_src2_i  in  REGI_BITS  integer source addresses
src1_vec_i, src2_vec_i  in  1  operand 1/2 reads a vector register
vec_src1_i, vec_src2_i  in  VECT_BITS  vector source addresses
wr_int_i  in  1  instruction writes an integer register
int_dest_i  in  REGI_BITS  integer destination
wr_vec_i  in  1  instruction writes a vector register
vec_dest_i  in  VECT_BITS  vector destination
is_end_i  in  1  instruction is the end instruction
flush_i  in  1  discard the decode-stage instruction (taken jump)
int_we_i  in  1  integer writeback this cycle
int_wb_dest_i  in  REGI_BITS  integer writeback address
vec_we_i  in  1  vector writeback this cycle
vec_wb_dest_i  in  VECT_BITS  vector writeback address
issue_o  out  1  instruction advances into ID/EX this cycle
stall_o  out  1  hold fetch/decode
int_busy_o  out  2**REGI_BITS  integer pending bitmap
vec_busy_o  out  2**VECT_BITS  vector pending bitmap
outstanding_o  out  CNT_BITS  number of pending writes
halted_o  out  1  program drained and stopped
error_o  out  1  sticky stall-timeout flag

Behaviour:
- Reset: pending bitmaps = 0, outstanding_o = 0, state RUN, stall counter = 0, halted_o = 0, error_o = 0.
- Reset has immediate effect; mid-drain it abandons the drain.
- Hazard check, combinational on inputs plus state:
  - RAW: an enabled source register whose pending bit is set.
  - WAW: the enabled destination's pending bit is set.
  - With BYPASS_WB = 1, a pending bit being cleared this cycle by a matching writeback counts as not pending. With BYPASS_WB = 0 it still counts as pending.
- Issue rule: issue_o = issue_valid_i & ~hazard & ~flush_i & state == RUN.
- Stall rule: stall_o = issue_valid_i & ~flush_i & ~issue_o. Both outputs are combinational, with 0-cycle latency.
- Pending bit update, per register, on the clock edge:
  - Set when issue_o and that register is the enabled destination.
  - Cleared when a matching writeback occurs.
  - Set and clear on the same register in the same cycle: set wins.
  - The integer and vector files are fully independent.
- Integer and vector writes are both allowed from one instruction. Each sets its own bit and counts as 2 toward the outstanding count.
- outstanding_o: +1 per bit set, -1 per bit cleared, net change applied in the same cycle. It saturates at 2**CNT_BITS-1 and does not decrement below 0.
- A writeback to a non-pending register is ignored: no count change.
- flush_i: suppresses issue for that cycle only. Pending bits and counts are untouched, because in-flight instructions still write back.
- FSM:
  - RUN: issue_o & is_end_i → DRAIN. The end instruction itself issues.
  - DRAIN: issue_o = 0. When both bitmaps are zero (after this cycle's clears) → HALT.
  - HALT: halted_o = 1; issue_o = 0; stall_o follows the stall rule. Only rst exits HALT.
- Watchdog:
  - The counter increments each cycle stall_o = 1 in RUN, and resets to 0 otherwise.
  - When the counter reaches TIMEOUT, error_o is set to 1 and stays set until rst.
  - The counter saturates.

Test Plan:
- Issue ADD r3 (wr_int, dest 3); next cycle src1 = r3, no writeback → issue_o = 0, stall_o = 1, int_busy_o[3] = 1. Then int_we_i with dest 3: BYPASS_WB = 1 → issue_o = 1 in that same cycle; BYPASS_WB = 0 → issue_o = 1 one cycle later.
- Vector v2 pending; an instruction with dest v2 and no vector sources → WAW stall. A concurrent integer writeback to r2 does not release it.
- Same cycle: issue dest r5 while writeback r5 clears an older write → int_busy_o[5] = 1 after the edge, outstanding_o unchanged.
- flush_i = 1 with a hazard-free valid instruction → issue_o = 0, stall_o = 0, no bitmap change.
- Two writes pending, then the end instruction issues → DRAIN with issue_o = 0. After the two writebacks, halted_o = 1 on the following edge; assert rst → all outputs 0, state RUN.
- TIMEOUT = 64 with r1 pending and never written back → error_o = 1 after 64 stall cycles, and stays 1 until rst.
